// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, the hit-count writeback address and the
// state encoding of the N-way data cache controller.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t DCACHE_COUNT_ADDR = 32'h3100;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    LOAD,
    FLUSH_CHK,
    FLUSH_WB,
    WRITE_CNT,
    HALT
  } dcache_nway_state_t;

endpackage

// File: rtl/dcache_lru.sv
// True-LRU bookkeeping for one set: ages after an access to acc_way_i, and
// the replacement victim (lowest invalid way, else the oldest way).
module dcache_lru #(
  parameter int WAYS = 2,
  parameter int AW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0][AW-1:0] ages_i,
  input  logic [WAYS-1:0]         valid_i,
  input  logic [AW-1:0]           acc_way_i,
  output logic [WAYS-1:0][AW-1:0] ages_o,
  output logic [AW-1:0]           victim_o
);

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_age
    always_comb begin
      if (AW'(gi) == acc_way_i) begin
        ages_o[gi] = '0;
      end else if (ages_i[gi] < ages_i[acc_way_i]) begin
        ages_o[gi] = ages_i[gi] + 1'b1;
      end else begin
        ages_o[gi] = ages_i[gi];
      end
    end
  end

  logic found_invalid;

  always_comb begin
    victim_o      = '0;
    found_invalid = 1'b0;
    // Descending scan so the lowest-numbered invalid way is the last one kept.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o      = AW'(w);
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages_i[w] == AW'(WAYS - 1)) victim_o = AW'(w);
      end
    end
  end

endmodule

// File: rtl/dcache_nway.sv
// Write-back, write-allocate N-way set-associative data cache with true LRU,
// full dirty flush on halt and a final hit-minus-miss count write.
module dcache_nway
  import cpu_types_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int SETS        = 8,
  parameter int BLOCK_WORDS = 2
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  halt,
  input  logic  dmemREN,
  input  logic  dmemWEN,
  input  word_t dmemaddr,
  input  word_t dmemstore,
  output logic  dhit,
  output word_t dmemload,
  output logic  flushed,
  output logic  dREN,
  output logic  dWEN,
  output word_t daddr,
  output word_t dstore,
  input  logic  dwait,
  input  word_t dload
);

  localparam int AW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int IB = $clog2(SETS);
  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int OW = (OB > 0) ? OB : 1;
  localparam int TW = 30 - OB - IB;
  localparam int NF = SETS * WAYS;
  localparam int FW = $clog2(NF + 1);

  function automatic word_t mk_addr(input logic [TW-1:0] t, input logic [IB-1:0] s,
                                    input logic [OW-1:0] w);
    word_t a;
    a = '0;
    a[31 -: TW] = t;
    a[2 + OB +: IB] = s;
    if (OB > 0) a[2 +: OW] = w;
    return a;
  endfunction

  logic [TW-1:0] req_tag;
  logic [IB-1:0] req_idx;
  logic [OW-1:0] req_off;
  logic          unused_byte_bits;

  assign req_tag          = dmemaddr[31 -: TW];
  assign req_idx          = dmemaddr[2 + OB +: IB];
  assign req_off          = (OB > 0) ? dmemaddr[2 +: OW] : '0;
  assign unused_byte_bits = ^dmemaddr[1:0];

  word_t                  data_q  [WAYS][SETS][BLOCK_WORDS];
  logic [TW-1:0]          tag_q   [WAYS][SETS];
  logic [WAYS-1:0]        valid_q [SETS];
  logic [WAYS-1:0]        dirty_q [SETS];
  logic [WAYS-1:0][AW-1:0] age_q  [SETS];

  dcache_nway_state_t state_q;
  logic [OW-1:0] wc_q;
  logic [FW-1:0] f_q;
  logic [AW-1:0] vic_q;
  logic [IB-1:0] midx_q;
  logic [TW-1:0] mtag_q;
  word_t         hit_cnt_q, miss_cnt_q;

  logic [WAYS-1:0] match;
  logic [AW-1:0]   hit_way, victim;
  logic [WAYS-1:0][AW-1:0] lru_ages;
  logic req, is_wr, accept, last_word;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_match
    assign match[gi] = valid_q[req_idx][gi] && (tag_q[gi][req_idx] == req_tag);
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (match[w]) hit_way = AW'(w);
    end
  end

  dcache_lru #(.WAYS(WAYS), .AW(AW)) u_lru (
    .ages_i   (age_q[req_idx]),
    .valid_i  (valid_q[req_idx]),
    .acc_way_i(hit_way),
    .ages_o   (lru_ages),
    .victim_o (victim)
  );

  // A simultaneous read and write request is served as a read.
  assign req       = dmemREN | dmemWEN;
  assign is_wr     = dmemWEN & ~dmemREN;
  assign dhit      = (state_q == IDLE) && req && (|match);
  assign dmemload  = dhit ? data_q[hit_way][req_idx][req_off] : '0;
  assign flushed   = (state_q == HALT);
  assign accept    = ~dwait;
  assign last_word = (wc_q == OW'(BLOCK_WORDS - 1));

  logic [AW-1:0] f_way, wb_way;
  logic [IB-1:0] f_set, wb_set;

  assign f_set  = f_q[IB-1:0];
  assign f_way  = (WAYS > 1) ? f_q[IB +: AW] : '0;
  assign wb_way = (state_q == FLUSH_WB) ? f_way : vic_q;
  assign wb_set = (state_q == FLUSH_WB) ? f_set : midx_q;

  always_comb begin
    dREN   = 1'b0;
    dWEN   = 1'b0;
    daddr  = '0;
    dstore = '0;
    case (state_q)
      WB, FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = mk_addr(tag_q[wb_way][wb_set], wb_set, wc_q);
        dstore = data_q[wb_way][wb_set][wc_q];
      end
      LOAD: begin
        dREN  = 1'b1;
        daddr = mk_addr(mtag_q, midx_q, wc_q);
      end
      WRITE_CNT: begin
        dWEN   = 1'b1;
        daddr  = DCACHE_COUNT_ADDR;
        dstore = hit_cnt_q - miss_cnt_q;
      end
      default: ;
    endcase
  end

  // Single write port into the frame store: store hits and line fills.
  logic          dwe;
  logic [AW-1:0] dwe_way;
  logic [IB-1:0] dwe_set;
  logic [OW-1:0] dwe_off;
  word_t         dwe_data;

  always_comb begin
    dwe      = 1'b0;
    dwe_way  = hit_way;
    dwe_set  = req_idx;
    dwe_off  = req_off;
    dwe_data = dmemstore;
    if (dhit && is_wr) begin
      dwe = 1'b1;
    end else if (state_q == LOAD && accept) begin
      dwe      = 1'b1;
      dwe_way  = vic_q;
      dwe_set  = midx_q;
      dwe_off  = wc_q;
      dwe_data = dload;
    end
  end

  always_ff @(posedge CLK) begin
    if (dwe) data_q[dwe_way][dwe_set][dwe_off] <= dwe_data;
    if (state_q == LOAD && accept && last_word) tag_q[vic_q][midx_q] <= mtag_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      wc_q       <= '0;
      f_q        <= '0;
      vic_q      <= '0;
      midx_q     <= '0;
      mtag_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      end
    end else begin
      if (dhit) hit_cnt_q <= hit_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (dhit) begin
            age_q[req_idx] <= lru_ages;
            if (is_wr) dirty_q[req_idx][hit_way] <= 1'b1;
          end
          if (halt) begin
            f_q     <= '0;
            state_q <= FLUSH_CHK;
          end else if (req && !(|match)) begin
            vic_q   <= victim;
            midx_q  <= req_idx;
            mtag_q  <= req_tag;
            wc_q    <= '0;
            state_q <= (valid_q[req_idx][victim] && dirty_q[req_idx][victim]) ? WB : LOAD;
          end
        end
        WB: if (accept) begin
          wc_q <= last_word ? '0 : wc_q + 1'b1;
          if (last_word) state_q <= LOAD;
        end
        LOAD: if (accept) begin
          wc_q <= last_word ? '0 : wc_q + 1'b1;
          if (last_word) begin
            valid_q[midx_q][vic_q] <= 1'b1;
            dirty_q[midx_q][vic_q] <= 1'b0;
            miss_cnt_q             <= miss_cnt_q + 1'b1;
            state_q                <= IDLE;
          end
        end
        FLUSH_CHK: begin
          if (f_q == FW'(NF)) begin
            state_q <= WRITE_CNT;
          end else if (dirty_q[f_set][f_way]) begin
            wc_q    <= '0;
            state_q <= FLUSH_WB;
          end else begin
            f_q <= f_q + 1'b1;
          end
        end
        FLUSH_WB: if (accept) begin
          wc_q <= last_word ? '0 : wc_q + 1'b1;
          if (last_word) begin
            f_q     <= f_q + 1'b1;
            state_q <= FLUSH_CHK;
          end
        end
        WRITE_CNT: if (accept) state_q <= HALT;
        HALT: ;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway (4 ways): memory transactions are queued as
// expectations before each request and popped as the cache performs them.
module tb_dcache_nway;

  logic        CLK = 1'b0;
  logic        RST, halt, dmemREN, dmemWEN, dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload;

  dcache_nway #(.WAYS(4), .SETS(8), .BLOCK_WORDS(2)) dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        sb[$];
  txn_t        mon_t;
  logic [31:0] mem [logic [31:0]];
  int          n_cmp = 0, n_err = 0;
  int          hits = 0, misses = 0;
  bit          stretch = 0, hold = 0, prev_wait = 0;
  int          wcnt = 0;
  logic [31:0] prev_addr, prev_store;
  logic [1:0]  prev_dir;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input logic [31:0] a);
    txn_t t;
    t.wr = 1'b0; t.addr = a; t.data = '0;
    sb.push_back(t);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = 1'b1; t.addr = a; t.data = d;
    sb.push_back(t);
  endtask

  // Memory model: drives dwait/dload on the falling edge and scores each accepted word.
  always @(negedge CLK) begin
    if (RST) begin
      dwait = 1'b0; wcnt = 0; prev_wait = 1'b0;
    end else if (dREN || dWEN) begin
      check("ren_wen_exclusive", {31'b0, dREN & dWEN}, 32'd0);
      if (prev_wait) begin
        check("stable_addr", daddr, prev_addr);
        check("stable_store", dstore, prev_store);
        check("stable_dir", {30'b0, dREN, dWEN}, {30'b0, prev_dir});
      end
      if (hold) begin
        dwait = 1'b1;
      end else if (stretch && wcnt < 3) begin
        dwait = 1'b1; wcnt++;
      end else begin
        dwait = 1'b0; wcnt = 0;
      end
      dload = dREN ? mem_rd(daddr) : 32'h0;
      if (!dwait) begin
        $display("mem %s addr=%h data=%h", dWEN ? "WR" : "RD", daddr, dWEN ? dstore : dload);
        check("expected_txn", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_t = sb.pop_front();
          check("mem_dir", {31'b0, dWEN}, {31'b0, mon_t.wr});
          check("mem_addr", daddr, mon_t.addr);
          if (mon_t.wr) check("mem_data", dstore, mon_t.data);
        end
        if (dWEN) mem[daddr] = dstore;
      end
      prev_wait  = dwait;
      prev_addr  = daddr;
      prev_store = dstore;
      prev_dir   = {dREN, dWEN};
    end else begin
      dwait = 1'b0; wcnt = 0; prev_wait = 1'b0;
    end
  end

  task automatic req(input bit ren, input bit wen, input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat, input logic [31:0] exp_data, input bit chk_data,
                     input string tag);
    int lat;
    bit got;
    @(negedge CLK);
    dmemREN = ren; dmemWEN = wen; dmemaddr = a; dmemstore = d;
    lat = 0; got = 1'b0;
    #1;
    while (!got && lat < 400) begin
      if (dhit) got = 1'b1;
      else begin
        @(negedge CLK); #1; lat++;
      end
    end
    check({tag, "_hit"}, {31'b0, got}, 32'd1);
    if (got) begin
      hits++;
      if (lat > 0) misses++;
      if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
      if (chk_data) check({tag, "_data"}, dmemload, exp_data);
    end
    $display("req %s ren=%0d wen=%0d addr=%h lat=%0d load=%h", tag, ren, wen, a, lat, dmemload);
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_dhit"}, {31'b0, dhit}, 32'd0);
    check({tag, "_dREN"}, {31'b0, dREN}, 32'd0);
    check({tag, "_dWEN"}, {31'b0, dWEN}, 32'd0);
    check({tag, "_daddr"}, daddr, 32'd0);
    check({tag, "_dstore"}, dstore, 32'd0);
    check({tag, "_dmemload"}, dmemload, 32'd0);
  endtask

  initial begin
    int k;
    RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    dmemaddr = '0; dmemstore = '0; dwait = 1'b0; dload = '0;
    repeat (2) @(negedge CLK);
    #1;
    check_quiet("reset");
    check("reset_flushed", {31'b0, flushed}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Clean miss, then zero-latency hit on the other word of the block.
    push_rd(32'h40); push_rd(32'h44);
    req(1, 0, 32'h40, 0, 3, init_val(32'h40), 1, "clean_miss");
    check("clean_miss_sb", 32'(sb.size()), 32'd0);
    req(1, 0, 32'h44, 0, 0, init_val(32'h44), 1, "hit_44");

    // Fill set 0, dirty 0x80, then touch the rest so 0x80 becomes LRU.
    push_rd(32'h80);  push_rd(32'h84);
    req(1, 0, 32'h80, 0, 3, init_val(32'h80), 1, "fill_80");
    push_rd(32'hC0);  push_rd(32'hC4);
    req(1, 0, 32'hC0, 0, 3, init_val(32'hC0), 1, "fill_c0");
    push_rd(32'h100); push_rd(32'h104);
    req(1, 0, 32'h100, 0, 3, init_val(32'h100), 1, "fill_100");
    req(0, 1, 32'h80, 32'hDEAD_BEEF, 0, 0, 0, "store_80");
    req(1, 0, 32'hC0, 0, 0, init_val(32'hC0), 1, "touch_c0");
    req(1, 0, 32'h100, 0, 0, init_val(32'h100), 1, "touch_100");
    req(1, 0, 32'h40, 0, 0, init_val(32'h40), 1, "touch_40");
    push_wr(32'h80, 32'hDEAD_BEEF); push_wr(32'h84, init_val(32'h84));
    push_rd(32'h140); push_rd(32'h144);
    req(1, 0, 32'h140, 0, 5, init_val(32'h140), 1, "evict_80");
    check("evict_sb", 32'(sb.size()), 32'd0);
    req(0, 1, 32'h140, 32'hCAFE_F00D, 0, 0, 0, "store_140");
    req(1, 0, 32'h40, 0, 0, init_val(32'h40), 1, "untouched_40");
    req(1, 0, 32'hC0, 0, 0, init_val(32'hC0), 1, "untouched_c0");
    req(1, 0, 32'h100, 0, 0, init_val(32'h100), 1, "untouched_100");

    // Dirty miss with every word stretched by three dwait cycles.
    stretch = 1'b1;
    push_wr(32'h140, 32'hCAFE_F00D); push_wr(32'h144, init_val(32'h144));
    push_rd(32'h80); push_rd(32'h84);
    req(1, 0, 32'h80, 0, 17, 32'hDEAD_BEEF, 1, "stretch_80");
    stretch = 1'b0;
    check("stretch_sb", 32'(sb.size()), 32'd0);

    // Read and write together on a hit behave as a read.
    req(1, 1, 32'h44, 32'h1111_1111, 0, init_val(32'h44), 1, "renwen_44");
    req(1, 0, 32'h44, 0, 0, init_val(32'h44), 1, "after_renwen_44");

    // Reset while the second word of a fill is outstanding.
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; hits = 0; misses = 0;
    push_rd(32'h200);
    @(negedge CLK);
    dmemREN = 1'b1; dmemaddr = 32'h200;
    @(negedge CLK);
    #1 hold = 1'b1;
    @(negedge CLK);
    #1;
    check("midload_dREN", {31'b0, dREN}, 32'd1);
    check("midload_daddr", daddr, 32'h204);
    #1 RST = 1'b1;
    #1;
    check_quiet("async_reset");
    dmemREN = 1'b0; hold = 1'b0;
    check("midload_sb", 32'(sb.size()), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    push_rd(32'h200); push_rd(32'h204);
    req(1, 0, 32'h200, 0, 3, init_val(32'h200), 1, "post_reset_miss");

    // Dirty set 3 way 0 and set 1 way 1, then halt and flush.
    push_rd(32'h18); push_rd(32'h1C);
    req(1, 0, 32'h18, 0, 3, init_val(32'h18), 1, "fill_18");
    req(0, 1, 32'h18, 32'hA1A1_A1A1, 0, 0, 0, "store_18");
    push_rd(32'h08); push_rd(32'h0C);
    req(1, 0, 32'h08, 0, 3, init_val(32'h08), 1, "fill_08");
    push_rd(32'h48); push_rd(32'h4C);
    req(0, 1, 32'h48, 32'hB2B2_B2B2, 3, 0, 0, "store_miss_48");
    req(1, 1, 32'h08, 32'h1111_1111, 0, init_val(32'h08), 1, "renwen_08");
    push_wr(32'h18, 32'hA1A1_A1A1); push_wr(32'h1C, init_val(32'h1C));
    push_wr(32'h48, 32'hB2B2_B2B2); push_wr(32'h4C, init_val(32'h4C));
    push_wr(32'h3100, 32'(hits - misses));
    @(negedge CLK);
    halt = 1'b1;
    k = 0;
    #1;
    while (!flushed && k < 200) begin
      @(negedge CLK); #1; k++;
    end
    check("flushed_set", {31'b0, flushed}, 32'd1);
    halt = 1'b0;
    check("flush_sb", 32'(sb.size()), 32'd0);
    $display("halt flushed after %0d cycles", k);
    dmemREN = 1'b1; dmemaddr = 32'h18;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); #1;
      check("halt_flushed_hold", {31'b0, flushed}, 32'd1);
      check("halt_no_dhit", {31'b0, dhit}, 32'd0);
      check("halt_no_mem", {30'b0, dREN, dWEN}, 32'd0);
    end
    dmemREN = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
